rv32i_multicycle_ctrl: RTL

- Multi-cycle control FSM that sequences the RV32I datapath.
- Each instruction runs through FETCH/DECODE/EXEC/MEM/WB. The block drives every datapath select and enable from the latched instruction and the current state.
- It replaces the current hardwired PCSel/RegWEn constants and the undriven select lines.
- It also supports data-memory wait states, flags illegal instructions, and counts retired instructions.

---
 rtl/rv32i_multicycle_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_multicycle_ctrl
//   Multi-cycle control FSM for an RV32I datapath. The instruction word is
//   latched into an internal IR during FETCH. Every datapath select and enable
//   is then derived from IR and the current state. The block also adds
//   data-memory wait states, a sticky illegal-instruction trap and a
//   retired-instruction counter.
//
// Parameters
//   MEM_WAIT_EN : 1 = MEM waits for mem_ready, 0 = MEM always lasts one cycle
//   CNT_W       : width of the instret counter (wraps)
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   instr[31:0]         instruction word from instruction memory
//   br_eq, br_lt        branch comparator results
//   mem_ready           data-memory access complete
//   pc_we, pc_sel       PC load enable / 0 = PC+4, 1 = ALU
//   ir_we               IR load (FETCH)
//   reg_we              register-file write enable
//   a_sel, b_sel        ALU operand selects (PC / immediate)
//   alu_sel[4:0]        ALU operation
//   imm_sel[2:0]        immediate format I/S/B/U/J
//   br_un               unsigned branch compare
//   mem_rw              data-memory write
//   wb_sel[1:0]         write-back source DataR / ALU / PC+4
//   illegal             sticky illegal-instruction flag
//   instret[CNT_W-1:0]  retired-instruction count
// ---------------------------------------------------------------------------
module rv32i_multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic             a_sel,
  output logic             b_sel,
  output logic [4:0]       alu_sel,
  output logic [2:0]       imm_sel,
  output logic             br_un,
  output logic             mem_rw,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  state_e             state_q, state_d;
  logic [31:0]        ir_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   instret_q;

  // ---------------------------------------------------------------------
  // Instruction fields (always from IR, never from the live instr bus)
  // ---------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_ir;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign funct7b5 = ir_q[30];
  // Register indices and immediates are consumed by the datapath, not here.
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic op_legal;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);

  // funct3 010/011 are unassigned branch encodings.
  assign op_legal = (is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr |
                     is_lui | is_auipc) && !(is_br && (funct3[2:1] == 2'b01));

  // Shared funct3 -> ALU map; alt picks SUB for 000 and SRA for 101.
  function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [4:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Per-instruction datapath selects, held for EXEC/MEM/WB
  // ---------------------------------------------------------------------
  logic       dec_a, dec_b;
  logic [4:0] dec_alu;
  logic [2:0] dec_imm;
  logic [1:0] dec_wb;

  always_comb begin
    dec_a   = 1'b0;
    dec_b   = 1'b0;
    dec_alu = ALU_ADD;
    dec_imm = IMM_I;
    dec_wb  = WB_ALU;
    if (is_r) begin
      dec_alu = alu_of(funct3, funct7b5);
    end
    if (is_i) begin
      // funct7[5] is an immediate bit for everything except SRAI.
      dec_b   = 1'b1;
      dec_alu = alu_of(funct3, funct7b5 && (funct3 == 3'b101));
    end
    if (is_ld) begin
      dec_b  = 1'b1;
      dec_wb = WB_MEM;
    end
    if (is_st) begin
      dec_b   = 1'b1;
      dec_imm = IMM_S;
    end
    if (is_br) begin
      dec_a   = 1'b1;
      dec_b   = 1'b1;
      dec_imm = IMM_B;
    end
    if (is_jal) begin
      dec_a   = 1'b1;
      dec_b   = 1'b1;
      dec_imm = IMM_J;
      dec_wb  = WB_PC4;
    end
    if (is_jalr) begin
      dec_b  = 1'b1;
      dec_wb = WB_PC4;
    end
    if (is_lui) begin
      dec_b   = 1'b1;
      dec_imm = IMM_U;
      dec_alu = ALU_PASSB;
    end
    if (is_auipc) begin
      dec_a   = 1'b1;
      dec_b   = 1'b1;
      dec_imm = IMM_U;
    end
  end

  // Branch condition; comparator signedness comes from br_un driven below.
  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:         br_taken = br_eq;
      3'b001:         br_taken = !br_eq;
      3'b100, 3'b110: br_taken = br_lt;
      3'b101, 3'b111: br_taken = !br_lt;
      default:        br_taken = 1'b0;
    endcase
  end

  logic mem_done;
  assign mem_done = !MEM_WAIT_EN || mem_ready;

  // ---------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    alu_sel = ALU_ADD;
    imm_sel = IMM_I;
    br_un   = 1'b0;
    mem_rw  = 1'b0;
    wb_sel  = WB_MEM;

    // Selects stay steady from EXEC until the instruction leaves WB.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      a_sel   = dec_a;
      b_sel   = dec_b;
      alu_sel = dec_alu;
      imm_sel = dec_imm;
      wb_sel  = dec_wb;
    end

    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = op_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (is_br) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken;
          br_un   = (funct3[2:1] == 2'b11);
          state_d = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_rw = is_st;
        if (mem_done) begin
          if (is_st) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = is_jal || is_jalr;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset kills the in-flight instruction immediately, including a store.
    if (rst) begin
      pc_we   = 1'b0;
      pc_sel  = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      a_sel   = 1'b0;
      b_sel   = 1'b0;
      alu_sel = ALU_ADD;
      imm_sel = IMM_I;
      br_un   = 1'b0;
      mem_rw  = 1'b0;
      wb_sel  = WB_MEM;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'h0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we) ir_q <= instr;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      // Every PC update retires exactly one instruction.
      if (pc_we) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
